imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_if.sv | 27 ++
 rtl/imem_loader.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream load request and instruction-RAM write bus of the instruction-memory loader.
// The master side issues requests and bytes; the loader sits on the slave side.
interface imem_loader_if;
    logic        start;
    logic [15:0] word_count;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_wren;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic [15:0] checksum;
    logic        error;

    modport master (
        output start, word_count, byte_in, byte_valid,
        input  byte_ready, mem_addr, mem_data, mem_wren, cpu_hold, busy, done, checksum, error
    );

    modport slave (
        input  start, word_count, byte_in, byte_valid,
        output byte_ready, mem_addr, mem_data, mem_wren, cpu_hold, busy, done, checksum, error
    );
endinterface

// File: rtl/imem_loader.sv
// Assembles big-endian byte pairs into 16-bit words and writes them to instruction RAM.
// Define IMEM_LOADER_TIMEOUT_EN to abort a stalled load after TIMEOUT_CYCLES idle cycles.
module imem_loader #(
    parameter logic [15:0] BASE_ADDR      = 16'h0000,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input logic          clk,
    input logic          reset,
    imem_loader_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StHi, StLo, StWrite, StDone} state_e;

    state_e      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [15:0] index_q, index_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic [15:0] sum_q, sum_d;
    logic [7:0]  hi_q, hi_d;
    logic [16:0] index_inc;
    logic        byte_acc;
    logic        timeout;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("imem_loader: TIMEOUT_CYCLES must be nonzero");
    end

    assign byte_acc  = bus.byte_valid && ((state_q == StHi) || (state_q == StLo));
    // One extra bit so a count of 16'hFFFF still compares correctly.
    assign index_inc = {1'b0, index_q} + 17'd1;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        index_d = index_q;
        addr_d  = addr_q;
        data_d  = data_q;
        sum_d   = sum_q;
        hi_d    = hi_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    count_d = bus.word_count;
                    index_d = '0;
                    sum_d   = '0;
                    state_d = (bus.word_count == 16'h0000) ? StDone : StHi;
                end
            end
            StHi: begin
                if (byte_acc) begin
                    hi_d    = bus.byte_in;
                    state_d = StLo;
                end else if (timeout) begin
                    state_d = StIdle;
                end
            end
            StLo: begin
                // Address and data are captured here so they are stable through WRITE and after.
                if (byte_acc) begin
                    data_d  = {hi_q, bus.byte_in};
                    addr_d  = BASE_ADDR + index_q;
                    state_d = StWrite;
                end else if (timeout) begin
                    state_d = StIdle;
                end
            end
            StWrite: begin
                sum_d   = sum_q + data_q;
                index_d = index_inc[15:0];
                state_d = (index_inc == {1'b0, count_q}) ? StDone : StHi;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            count_q <= '0;
            index_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            sum_q   <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            index_q <= index_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            sum_q   <= sum_d;
            hi_q    <= hi_d;
        end
    end

`ifdef IMEM_LOADER_TIMEOUT_EN
    localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);

    logic [IdleW-1:0] idle_q, idle_d;
    logic             error_q, error_d;

    always_comb begin
        idle_d  = idle_q;
        error_d = error_q;
        timeout = 1'b0;
        if (((state_q == StHi) || (state_q == StLo)) && !bus.byte_valid) begin
            if (idle_q == IdleW'(TIMEOUT_CYCLES - 1)) begin
                timeout = 1'b1;
                idle_d  = '0;
                error_d = 1'b1;
            end else begin
                idle_d = idle_q + IdleW'(1);
            end
        end else begin
            idle_d = '0;
        end
        if ((state_q == StIdle) && bus.start) begin
            error_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idle_q  <= '0;
            error_q <= 1'b0;
        end else begin
            idle_q  <= idle_d;
            error_q <= error_d;
        end
    end

    assign bus.error = error_q;
`else
    assign timeout   = 1'b0;
    assign bus.error = 1'b0;
`endif

    assign bus.byte_ready = (state_q == StHi) || (state_q == StLo);
    assign bus.mem_wren   = (state_q == StWrite);
    assign bus.busy       = (state_q != StIdle);
    assign bus.cpu_hold   = (state_q != StIdle);
    assign bus.done       = (state_q == StDone);
    assign bus.mem_addr   = addr_q;
    assign bus.mem_data   = data_q;
    assign bus.checksum   = sum_q;

endmodule
